// File: rtl/imm_gen_pipe.sv
// LEGv8 immediate generator with a DEPTH-entry result FIFO between fetch and decode/execute.
// Decodes the instruction format on push and queues {imm, fmt, illegal} for in-order delivery.
module imm_gen_pipe #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 2,
  parameter int BR_SHL2 = 1,
  parameter int I_ZEXT  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  instr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_imm,
  output logic [2:0]                   out_fmt,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BR_SH = (BR_SHL2 != 0) ? 2 : 0;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_D    = 3'd2,
    FMT_CB   = 3'd3,
    FMT_B    = 3'd4,
    FMT_I    = 3'd5,
    FMT_IW   = 3'd6
  } fmt_e;

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    fmt_e              fmt;
    logic              illegal;
  } entry_t;

  entry_t            w_dec;
  entry_t            w_head;
  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  // Every immediate is formed as a 64-bit value and then truncated to DATA_W,
  // so MOVZ halfwords placed above DATA_W simply vanish.
  always_comb begin
    // NOTE: always_comb assigns every output a default first, so no path leaves a latch.
    w_dec.imm     = '0;
    w_dec.fmt     = FMT_NONE;
    w_dec.illegal = 1'b0;
    if (instr[31:21] == 11'b11010011011 || instr[31:21] == 11'b11010011010) begin
      w_dec.fmt = FMT_R;
      w_dec.imm = DATA_W'({58'd0, instr[15:10]});
    end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
      w_dec.fmt = FMT_D;
      w_dec.imm = DATA_W'({{55{instr[20]}}, instr[20:12]});
    end else if (instr[31:24] == 8'b10110100 || instr[31:24] == 8'b01010100) begin
      w_dec.fmt = FMT_CB;
      w_dec.imm = DATA_W'({{45{instr[23]}}, instr[23:5]} << BR_SH);
    end else if (instr[31:26] == 6'b000101) begin
      w_dec.fmt = FMT_B;
      w_dec.imm = DATA_W'({{38{instr[25]}}, instr[25:0]} << BR_SH);
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      w_dec.fmt = FMT_I;
      if (I_ZEXT != 0) w_dec.imm = DATA_W'({52'd0, instr[21:10]});
      else             w_dec.imm = DATA_W'({{52{instr[21]}}, instr[21:10]});
    end else if (instr[31:23] == 9'b110100101) begin
      w_dec.fmt = FMT_IW;
      w_dec.imm = DATA_W'({48'd0, instr[20:5]} << {instr[22:21], 4'b0000});
    end else begin
      w_dec.illegal = 1'b1;
    end
  end

  // Ready depends only on occupancy so the producer never sees a path from out_ready.
  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready & ~reset;
  assign w_pop     = out_valid & out_ready & ~reset;
  assign count     = r_count;

  // NOTE: the storage array has no reset; pointers and count define validity, so stale
  // contents are never observable and the array can map to plain flops or RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head fields are masked to zero when empty instead of showing a stale entry.
  assign w_head      = r_mem[r_rd_ptr];
  assign out_imm     = out_valid ? w_head.imm : '0;
  assign out_fmt     = out_valid ? w_head.fmt : FMT_NONE;
  assign out_illegal = out_valid & w_head.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a default instance (64b, <<2, sign-extended I) and a
// narrow instance (32b, word offsets, zero-extended I) share the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;

  logic        in_ready,  out_valid,  out_illegal;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [1:0]  count;

  logic        in_ready_n, out_valid_n, out_illegal_n;
  logic [31:0] out_imm_n;
  logic [2:0]  out_fmt_n;
  logic [1:0]  count_n;

  int n_checks = 0;
  int n_errors = 0;

  imm_gen_pipe u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .count(count)
  );

  imm_gen_pipe #(.DATA_W(32), .DEPTH(2), .BR_SHL2(0), .I_ZEXT(1)) u_dut_n (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_n), .instr(instr),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_imm(out_imm_n), .out_fmt(out_fmt_n),
    .out_illegal(out_illegal_n), .count(count_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    instr    = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    instr    = 32'hDEAD_BEEF;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [63:0] e64, input logic [31:0] e32,
                            input logic [2:0] fmt, input logic ill);
    check({tag, " valid"},   64'(out_valid),     64'd1);
    check({tag, " imm"},     out_imm,            e64);
    check({tag, " fmt"},     64'(out_fmt),       64'(fmt));
    check({tag, " illegal"}, 64'(out_illegal),   64'(ill));
    check({tag, " imm32"},   64'(out_imm_n),     64'(e32));
    check({tag, " fmt32"},   64'(out_fmt_n),     64'(fmt));
  endtask

  task automatic check_empty(input string tag);
    check({tag, " valid"},    64'(out_valid),   64'd0);
    check({tag, " imm"},      out_imm,          64'd0);
    check({tag, " fmt"},      64'(out_fmt),     64'd0);
    check({tag, " illegal"},  64'(out_illegal), 64'd0);
    check({tag, " count"},    64'(count),       64'd0);
    check({tag, " in_ready"}, 64'(in_ready),    64'd1);
    check({tag, " valid32"},  64'(out_valid_n), 64'd0);
    check({tag, " imm32"},    64'(out_imm_n),   64'd0);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [63:0] e64;
    logic [31:0] e32;
    logic [2:0]  fmt;
    logic        ill;
    string       name;
  } vec_t;

  vec_t vecs [13];

  initial begin
    // Narrow instance: no branch shift, I-type zero-extended, upper MOVZ halfwords dropped.
    // 0xD2E579A0 carries imm16=0x2BCD (bit 20 clear); 0xD2F579A0 is the 0xABCD, LSL 48 form.
    vecs = '{
      '{32'hF85F8000, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd2, 1'b0, "ldur_m8"},
      '{32'hF80FF000, 64'h0000_0000_0000_00FF, 32'h0000_00FF, 3'd2, 1'b0, "stur_255"},
      '{32'h17FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 3'd4, 1'b0, "b_m1"},
      '{32'hD2E579A0, 64'h2BCD_0000_0000_0000, 32'h0000_0000, 3'd6, 1'b0, "movz_hw3_a"},
      '{32'hD2F579A0, 64'hABCD_0000_0000_0000, 32'h0000_0000, 3'd6, 1'b0, "movz_hw3_b"},
      '{32'hD2A24680, 64'h0000_0000_1234_0000, 32'h1234_0000, 3'd6, 1'b0, "movz_hw1"},
      '{32'h00000000, 64'h0,                   32'h0,         3'd0, 1'b1, "illegal"},
      '{32'hD360FC00, 64'h0000_0000_0000_003F, 32'h0000_003F, 3'd1, 1'b0, "lsl_63"},
      '{32'hD3401400, 64'h0000_0000_0000_0005, 32'h0000_0005, 3'd1, 1'b0, "lsr_5"},
      '{32'hB4FFFFC0, 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFFE, 3'd3, 1'b0, "cbz_m2"},
      '{32'h540000A0, 64'h0000_0000_0000_0014, 32'h0000_0005, 3'd3, 1'b0, "bcond_5"},
      '{32'h91200000, 64'hFFFF_FFFF_FFFF_F800, 32'h0000_0800, 3'd5, 1'b0, "addi_800"},
      '{32'hD11FFC00, 64'h0000_0000_0000_07FF, 32'h0000_07FF, 3'd5, 1'b0, "subi_7ff"}
    };

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = 32'h0;
    step(); step();
    check_empty("in_reset");
    reset = 1'b0;
    step();
    check_empty("post_reset");

    // instr with in_valid low must be ignored
    instr = 32'hF85F8000;
    step();
    check_empty("no_push");

    // one-cycle latency, no bypass: not visible before the push edge
    in_valid = 1'b1;
    #2;
    check("no_bypass valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("latency count", 64'(count), 64'd1);
    check_head("latency", 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd2, 1'b0);
    pop();
    check_empty("latency_pop");

    foreach (vecs[i]) begin
      push(vecs[i].ins);
      check({vecs[i].name, " count"}, 64'(count), 64'd1);
      check_head(vecs[i].name, vecs[i].e64, vecs[i].e32, vecs[i].fmt, vecs[i].ill);
      pop();
      check_empty({vecs[i].name, "_pop"});
    end

    // backpressure: fill, hold, then drain with a concurrent push
    push(32'hF85F8000);
    check("bp1 in_ready", 64'(in_ready), 64'd1);
    push(32'h17FFFFFF);
    check("bp2 in_ready", 64'(in_ready), 64'd0);
    check("bp2 count",    64'(count),    64'd2);
    instr = 32'hD2A24680; in_valid = 1'b1;
    step();
    check("bp3 count", 64'(count), 64'd2);
    check_head("bp3_hold", 64'hFFFF_FFFF_FFFF_FFF8, 32'hFFFF_FFF8, 3'd2, 1'b0);
    out_ready = 1'b1;
    step();
    check("bp_pop_full count", 64'(count), 64'd1);
    check_head("bp_second", 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFF, 3'd4, 1'b0);
    check("bp_pop_full in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_pushpop count", 64'(count), 64'd1);
    check_head("bp_third", 64'h0000_0000_1234_0000, 32'h1234_0000, 3'd6, 1'b0);
    step();
    out_ready = 1'b0;
    check_empty("bp_drained");

    // reset mid-operation discards entries; push/pop in the reset cycle are ignored
    push(32'hF85F8000);
    push(32'h17FFFFFF);
    check("pre_rst count", 64'(count), 64'd2);
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; instr = 32'hD360FC00;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("mid_reset");
    step();
    check_empty("after_mid_reset");
    push(32'hD3401400);
    check_head("restart", 64'h5, 32'h5, 3'd1, 1'b0);
    pop();
    check_empty("restart_pop");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
